// File: rtl/tx_rate_monitor.sv
// Converts the free-running TX packet count into per-interval packet rates,
// tracks the peak rate and holds each sample in a 1-deep valid/ready register.
module tx_rate_monitor #(
  parameter int          CNT_W           = 32,
  parameter logic [31:0] INTERVAL_CYCLES = 32'd250000,
  parameter int          IDX_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] tx_count,
  input  logic             enable,
  input  logic             clear,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic [CNT_W-1:0] rate_pkts,
  output logic [IDX_W-1:0] rate_idx,
  output logic [CNT_W-1:0] rate_max,
  output logic             overrun
);

  localparam logic [31:0] TERM = INTERVAL_CYCLES - 32'd1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [31:0]      timer;
  logic [CNT_W-1:0] baseline;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] delta;
  logic             terminal;
  logic             accept;

  // Unsigned subtraction absorbs a single wrap of the upstream counter.
  assign delta    = tx_count - baseline;
  assign terminal = (state == RUN) && enable && (timer == TERM);
  assign accept   = rate_valid && rate_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!clear) begin
      case (state)
        IDLE:    if (enable)  state_nx = RUN;
        RUN:     if (!enable) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer      <= '0;
      baseline   <= '0;
      idx        <= '0;
      rate_valid <= 1'b0;
      rate_pkts  <= '0;
      rate_idx   <= '0;
      rate_max   <= '0;
      overrun    <= 1'b0;
    end else if (clear) begin
      timer      <= '0;
      baseline   <= tx_count;
      idx        <= '0;
      rate_valid <= 1'b0;
      rate_max   <= '0;
      overrun    <= 1'b0;
    end else begin
      if (accept) rate_valid <= 1'b0;
      if (state == IDLE) begin
        timer <= '0;
        if (enable) baseline <= tx_count;
      end else if (!enable) begin
        // Partial interval is discarded.
        timer <= '0;
      end else if (terminal) begin
        timer    <= '0;
        baseline <= tx_count;
        idx      <= idx + 1'b1;
        if (delta > rate_max) rate_max <= delta;
        // Load when empty or when the held sample leaves this same cycle.
        if (!rate_valid || accept) begin
          rate_valid <= 1'b1;
          rate_pkts  <= delta;
          rate_idx   <= idx;
        end else begin
          overrun <= 1'b1;
        end
      end else begin
        timer <= timer + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_tx_rate_monitor.sv
// Directed bench for tx_rate_monitor with a 10-cycle interval; inputs change on
// the falling edge and outputs are sampled there, clear of the rising edge.
module tb_tx_rate_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tx_count;
  logic        enable, clear, rate_ready;
  logic        rate_valid, overrun;
  logic [31:0] rate_pkts, rate_max;
  logic [15:0] rate_idx;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tx_rate_monitor #(.CNT_W(32), .INTERVAL_CYCLES(32'd10), .IDX_W(16)) dut (
    .clk(clk), .rst(rst), .tx_count(tx_count), .enable(enable), .clear(clear),
    .rate_valid(rate_valid), .rate_ready(rate_ready), .rate_pkts(rate_pkts),
    .rate_idx(rate_idx), .rate_max(rate_max), .overrun(overrun)
  );

  // Leaves the bench at a falling edge with the DUT out of reset and idle.
  task automatic do_reset();
    rst = 1'b0; enable = 1'b0; clear = 1'b0; rate_ready = 1'b1; tx_count = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({rate_valid, overrun, rate_pkts, rate_idx, rate_max} !== 82'd0) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b ovr=%b pkts=%0d idx=%0d max=%0d, want all 0",
               rate_valid, overrun, rate_pkts, rate_idx, rate_max);
    end
  endtask

  // Enable at N0; terminal edges are the 11th, 21st, 31st rising edges after it.
  task automatic test_steady();
    do_reset();
    tx_count = 32'd100;
    enable = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 11 || k == 21 || k == 31) begin
        n_cmp++;
        if (rate_valid !== 1'b1 || rate_pkts !== 32'd5 || rate_idx !== 16'((k - 11) / 10) ||
            rate_max !== 32'd5) begin
          n_bad++;
          $display("FAIL steady_sample k=%0d: got v=%b pkts=%0d idx=%0d max=%0d, want v=1 pkts=5 idx=%0d max=5",
                   k, rate_valid, rate_pkts, rate_idx, rate_max, (k - 11) / 10);
        end
      end else if (k == 12 || k == 22 || k == 10) begin
        n_cmp++;
        if (rate_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL steady_pulse k=%0d: got v=%b, want v=0", k, rate_valid);
        end
      end
      if (k % 2 == 0) tx_count = tx_count + 32'd1;
    end
    enable = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    tx_count = 32'hFFFF_FFFD;
    enable = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      tx_count = tx_count + 32'd1;
    end
    n_cmp++;
    if (rate_valid !== 1'b1 || rate_pkts !== 32'd10 || rate_max !== 32'd10) begin
      n_bad++;
      $display("FAIL wrap: got v=%b pkts=%h max=%h, want v=1 pkts=a max=a",
               rate_valid, rate_pkts, rate_max);
    end
    enable = 1'b0;
  endtask

  task automatic test_back_pressure();
    do_reset();
    rate_ready = 1'b0;
    enable = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      case (k)
        5:  tx_count = 32'd3;
        11: begin
          n_cmp++;
          if (rate_valid !== 1'b1 || rate_pkts !== 32'd3 || rate_idx !== 16'd0 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_first: got v=%b pkts=%0d idx=%0d ovr=%b, want v=1 pkts=3 idx=0 ovr=0",
                     rate_valid, rate_pkts, rate_idx, overrun);
          end
        end
        15: tx_count = 32'd10;
        21: begin
          n_cmp++;
          if (rate_valid !== 1'b1 || rate_pkts !== 32'd3 || rate_idx !== 16'd0 ||
              overrun !== 1'b1 || rate_max !== 32'd7) begin
            n_bad++;
            $display("FAIL bp_hold: got v=%b pkts=%0d idx=%0d ovr=%b max=%0d, want v=1 pkts=3 idx=0 ovr=1 max=7",
                     rate_valid, rate_pkts, rate_idx, overrun, rate_max);
          end
        end
        22: rate_ready = 1'b1;
        23: begin
          n_cmp++;
          if (rate_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_drain: got v=%b, want v=0", rate_valid);
          end
        end
        25: tx_count = 32'd15;
        31: begin
          n_cmp++;
          if (rate_valid !== 1'b1 || rate_idx !== 16'd2 || rate_pkts !== 32'd5 ||
              rate_max !== 32'd7 || overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_next: got v=%b pkts=%0d idx=%0d max=%0d ovr=%b, want v=1 pkts=5 idx=2 max=7 ovr=1",
                     rate_valid, rate_pkts, rate_idx, rate_max, overrun);
          end
        end
        default: ;
      endcase
    end
    enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    rate_ready = 1'b0;
    enable = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      case (k)
        5:  tx_count = 32'd4;
        15: tx_count = 32'd10;
        20: rate_ready = 1'b1;
        21: begin
          rate_ready = 1'b0;
          n_cmp++;
          if (rate_valid !== 1'b1 || rate_pkts !== 32'd6 || rate_idx !== 16'd1 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_load: got v=%b pkts=%0d idx=%0d ovr=%b, want v=1 pkts=6 idx=1 ovr=0",
                     rate_valid, rate_pkts, rate_idx, overrun);
          end
        end
        22: begin
          n_cmp++;
          if (rate_valid !== 1'b1 || rate_idx !== 16'd1 || rate_pkts !== 32'd6) begin
            n_bad++;
            $display("FAIL b2b_hold: got v=%b pkts=%0d idx=%0d, want v=1 pkts=6 idx=1",
                     rate_valid, rate_pkts, rate_idx);
          end
        end
        default: ;
      endcase
    end
    enable = 1'b0;
  endtask

  // Clear sampled on the 18th edge, where the second window's timer is 6.
  task automatic test_clear();
    do_reset();
    rate_ready = 1'b0;
    enable = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      case (k)
        5:  tx_count = 32'd9;
        17: begin
          n_cmp++;
          if (rate_max !== 32'd9 || rate_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_pre: got max=%0d v=%b, want max=9 v=1", rate_max, rate_valid);
          end
          clear = 1'b1;
        end
        18: begin
          clear = 1'b0;
          n_cmp++;
          if (rate_max !== 32'd0 || rate_valid !== 1'b0 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_post: got max=%0d v=%b ovr=%b, want max=0 v=0 ovr=0",
                     rate_max, rate_valid, overrun);
          end
        end
        20: tx_count = 32'd13;
        27: begin
          n_cmp++;
          if (rate_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_early: got v=%b at 9 cycles after clear, want v=0", rate_valid);
          end
        end
        28: begin
          n_cmp++;
          if (rate_valid !== 1'b1 || rate_idx !== 16'd0 || rate_pkts !== 32'd4 || rate_max !== 32'd4) begin
            n_bad++;
            $display("FAIL clr_sample: got v=%b idx=%0d pkts=%0d max=%0d, want v=1 idx=0 pkts=4 max=4",
                     rate_valid, rate_idx, rate_pkts, rate_max);
          end
        end
        default: ;
      endcase
    end
    enable = 1'b0;
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    rate_ready = 1'b0;
    enable = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 5) tx_count = 32'd8;
    end
    n_cmp++;
    if (rate_valid !== 1'b1 || rate_max !== 32'd8) begin
      n_bad++;
      $display("FAIL ar_pre: got v=%b max=%0d, want v=1 max=8", rate_valid, rate_max);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({rate_valid, overrun, rate_pkts, rate_idx, rate_max} !== 82'd0) begin
      n_bad++;
      $display("FAIL ar_async: got v=%b ovr=%b pkts=%0d idx=%0d max=%0d, want all 0 before any edge",
               rate_valid, overrun, rate_pkts, rate_idx, rate_max);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // IDLE cycle + 10 RUN cycles + output latency: valid in the 12th cycle,
    // i.e. after the 11th rising edge following release.
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (rate_valid === 1'b1) break;
    end
    n_cmp++;
    if (rate_valid !== 1'b1 || n != 11) begin
      n_bad++;
      $display("FAIL ar_latency: got v=%b after %0d edges, want v=1 after 11 edges", rate_valid, n);
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_steady();
    test_wrap();
    test_back_pressure();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tx_rate_monitor.md
Name: tx_rate_monitor

Overview:
- Sits directly downstream of the TX packet counter. Consumes its free-running 32-bit `tx_count` and turns it into per-interval packet rates.
- Every `INTERVAL_CYCLES` clocks it computes the packet delta, tracks the peak, and presents the sample on a valid/ready register interface.
- The interface is read by the host stats/CSR logic.

Parameters:
- CNT_W, 32, width of `tx_count` and of all rate outputs
- INTERVAL_CYCLES, 250000, sample window length in clk cycles (1 ms at 250 MHz); legal range 2 to 2^32-1
- IDX_W, 16, width of the sample index counter

Ports:
- clk  input  1  core clock, shared with the TX counter
- rst  input  1  asynchronous, active-low reset
- tx_count  input  CNT_W  free-running packet count from the TX counter; wraps modulo 2^CNT_W
- enable  input  1  level; 1 = sampling runs, 0 = idle
- clear  input  1  synchronous single-cycle pulse; restarts statistics
- rate_valid  output  1  sample held in output register
- rate_ready  input  1  consumer accepts sample when rate_valid & rate_ready
- rate_pkts  output  CNT_W  packets in the sampled interval
- rate_idx  output  IDX_W  index of the held sample
- rate_max  output  CNT_W  largest rate_pkts computed since reset/clear
- overrun  output  1  sticky; a computed sample was dropped because the output register was occupied

Behaviour:
- Reset (rst=0, async): state=IDLE, timer=0, baseline=0, rate_valid=0, rate_pkts=0, rate_idx=0, rate_max=0, overrun=0, internal idx=0.
- FSM IDLE:
  - On enable=1: capture baseline<=tx_count, timer<=0, go RUN.
  - Timer holds 0.
- FSM RUN:
  - timer increments every cycle.
  - On the terminal cycle (timer==INTERVAL_CYCLES-1), using tx_count sampled that cycle:
    - delta = (tx_count - baseline) mod 2^CNT_W, so wrap is handled by unsigned subtraction.
    - baseline<=tx_count, timer<=0, internal idx<=idx+1 (wraps mod 2^IDX_W).
    - If delta > rate_max, then rate_max<=delta, visible the next cycle.
  - enable=0 in RUN: go IDLE next cycle; a partial interval is discarded (no sample).
- Sample latency: rate_valid/rate_pkts/rate_idx update 1 cycle after the terminal cycle. rate_idx = idx value before increment (first sample = 0).
- Output register (1-deep):
  - Load when empty, or when the current sample is being accepted (rate_valid & rate_ready) in the terminal cycle.
  - If full and not accepted in the terminal cycle: the old sample is retained, the new one is dropped, overrun<=1. rate_max and idx still update.
  - Accept with no new sample: rate_valid<=0 next cycle.
  - rate_pkts/rate_idx stable while rate_valid=1 and not accepted.
  - Ready may be held high permanently; valid never depends combinationally on ready.
- clear (priority over everything except reset):
  - rate_max<=0, overrun<=0, idx<=0, rate_valid<=0, timer<=0, baseline<=tx_count.
  - State unchanged; no sample is produced from that cycle's terminal event.
- enable=0 does not clear a held sample; it stays valid until read.
- INTERVAL_CYCLES comparison uses a 32-bit timer; no sample is possible faster than every 2 cycles.

Test Plan (bench uses INTERVAL_CYCLES=10, rate_ready=1 unless stated):
- Steady rate: tx_count incremented by 1 every 2 cycles from 100, enable at t0 -> rate_valid pulses every 10 cycles, rate_pkts=5, rate_idx=0,1,2…, rate_max=5.
- Wrap: tx_count starts at 0xFFFFFFFD, +1 per cycle -> first rate_pkts=10 (not 0xF…); rate_max=10.
- Back-pressure: rate_ready=0 across two terminal cycles, tx_count +3 then +7 per interval -> held rate_pkts=3, rate_idx=0; overrun=1; rate_max=7. After rate_ready=1, rate_valid drops, and the next sample has rate_idx=2.
- Accept-and-load same cycle: rate_ready pulsed exactly on the terminal cycle -> new sample loaded, rate_valid stays 1, overrun=0.
- clear mid-interval at timer=6 with rate_max=9 -> rate_max=0, rate_valid=0, next sample exactly 10 cycles after clear with rate_idx=0.
- Async reset asserted mid-RUN with rate_valid=1 -> all outputs 0 immediately without a clock edge. After release with enable=1, the first sample arrives INTERVAL_CYCLES+2 cycles after the release edge (1 cycle IDLE→RUN, interval, 1 cycle output latency).
